tl_cmd_parser: RTL and testbench

TL_CMD_PARSER -- requirements
Module: tl_cmd_parser

---
 rtl/tl_pkg.sv | 32 +++
 rtl/tl_cmd_parser.sv | 141 ++++++++++++++
 tb/tb_tl_cmd_parser.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tl_pkg.sv
// Shared definitions for the traffic-light command link: command types,
// default frame sync pattern and the parser state encoding.
package tl_pkg;

    typedef enum logic [2:0] {
        CMD_ON           = 3'd0,
        CMD_OFF          = 3'd1,
        CMD_UNCONTROLLED = 3'd2,
        CMD_GREEN_TIME   = 3'd3,
        CMD_RED_TIME     = 3'd4,
        CMD_YELLOW_TIME  = 3'd5
    } cmd_type_e;

    localparam logic [4:0] SYNC_HDR_DEFAULT = 5'b10101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_EMIT
    } parser_state_e;

    // Duration commands carry a 16-bit payload; switch commands carry none.
    function automatic logic has_payload(input logic [2:0] t);
        return (t >= CMD_GREEN_TIME) && (t <= CMD_YELLOW_TIME);
    endfunction

    function automatic logic is_legal_type(input logic [2:0] t);
        return t <= CMD_YELLOW_TIME;
    endfunction

endpackage

// File: rtl/tl_cmd_parser.sv
// Byte-stream frame parser for traffic-light commands: header {sync, type},
// optional two payload bytes (MSB first), inter-byte timeout and error strobe.
module tl_cmd_parser
    import tl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CLK = 1000,
    parameter logic [4:0]  SYNC_HDR    = SYNC_HDR_DEFAULT
) (
    input  logic        clk_i,
    input  logic        srst_i,
    input  logic [7:0]  byte_data_i,
    input  logic        byte_valid_i,
    output logic        byte_ready_o,
    output logic [2:0]  cmd_type_o,
    output logic [15:0] cmd_data_o,
    output logic        cmd_valid_o,
    output logic        err_o
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CLK + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CLK - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    parser_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       pend_type_q, pend_type_d;
    logic [2:0]       cmd_type_q, cmd_type_d;
    logic [15:0]      cmd_data_q, cmd_data_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic             err_q, err_d;
    logic             ready_q, ready_d;

    logic       xfer;
    logic       sync_ok;
    logic [2:0] hdr_type;
    logic       expired;

    assign xfer     = byte_valid_i & ready_q;
    assign sync_ok  = (byte_data_i[7:3] == SYNC_HDR);
    assign hdr_type = byte_data_i[2:0];
    assign expired  = (cnt_q == CNT_LAST) & ~xfer;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_type_d = pend_type_q;
        cmd_type_d  = cmd_type_q;
        cmd_data_d  = cmd_data_q;
        err_d       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (xfer) begin
                    if (!sync_ok || !is_legal_type(hdr_type)) begin
                        err_d = 1'b1;
                    end else if (has_payload(hdr_type)) begin
                        pend_type_d = hdr_type;
                        state_d     = ST_DATA_HI;
                    end else begin
                        cmd_type_d = hdr_type;
                        cmd_data_d = 16'h0000;
                        state_d    = ST_EMIT;
                    end
                end
            end

            ST_DATA_HI, ST_DATA_LO: begin
                if (xfer) begin
                    cnt_d = '0;
                    if (state_q == ST_DATA_HI) begin
                        cmd_data_d[15:8] = byte_data_i;
                        state_d          = ST_DATA_LO;
                    end else if ({cmd_data_q[15:8], byte_data_i} == 16'h0000) begin
                        // A zero duration would stall the light controller.
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cmd_data_d[7:0] = byte_data_i;
                        cmd_type_d      = pend_type_q;
                        state_d         = ST_EMIT;
                    end
                end else if (expired) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_EMIT: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end

            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        // Strobes and ready are registered from the next state so they line
        // up with the state they describe.
        cmd_valid_d = (state_d == ST_EMIT);
        ready_d     = (state_d != ST_EMIT);
    end

    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            pend_type_q <= 3'd0;
            cmd_type_q  <= 3'd0;
            cmd_data_q  <= 16'h0000;
            cmd_valid_q <= 1'b0;
            err_q       <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_type_q <= pend_type_d;
            cmd_type_q  <= cmd_type_d;
            cmd_data_q  <= cmd_data_d;
            cmd_valid_q <= cmd_valid_d;
            err_q       <= err_d;
            ready_q     <= ready_d;
        end
    end

    assign byte_ready_o = ready_q;
    assign cmd_type_o   = cmd_type_q;
    assign cmd_data_o   = cmd_data_q;
    assign cmd_valid_o  = cmd_valid_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_tl_cmd_parser.sv
// Self-checking bench for tl_cmd_parser: directed frames followed by random
// frame traffic, compared cycle by cycle against a frame-level model.
module tb_tl_cmd_parser;

    localparam int unsigned TMO  = 8;
    localparam logic [4:0]  SYNC = 5'b10101;

    logic        clk_i = 1'b0;
    logic        srst_i;
    logic [7:0]  byte_data_i;
    logic        byte_valid_i;
    logic        byte_ready_o;
    logic [2:0]  cmd_type_o;
    logic [15:0] cmd_data_o;
    logic        cmd_valid_o;
    logic        err_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: bytes of the frame collected so far and idle cycles since the last one.
    logic [7:0]  frame[$];
    int          gap;
    bit          bubble;
    logic        exp_valid, exp_err;
    logic [2:0]  exp_type;
    logic [15:0] exp_data;

    tl_cmd_parser #(
        .TIMEOUT_CLK (TMO),
        .SYNC_HDR    (SYNC)
    ) dut (
        .clk_i        (clk_i),
        .srst_i       (srst_i),
        .byte_data_i  (byte_data_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .cmd_type_o   (cmd_type_o),
        .cmd_data_o   (cmd_data_o),
        .cmd_valid_o  (cmd_valid_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of test, required end before 500000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        frame.delete();
        gap       = 0;
        bubble    = 1'b0;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        exp_type  = 3'd0;
        exp_data  = 16'h0000;
    endtask

    // Outcome of one cycle's input on the following cycle's outputs.
    task automatic model_step(input logic v, input logic [7:0] d);
        logic        nv, ne;
        logic [15:0] val;
        nv = 1'b0;
        ne = 1'b0;
        if (bubble) begin
            // byte offered while a command is being emitted is not taken
        end else if (v) begin
            frame.push_back(d);
            gap = 0;
            if (frame.size() == 1) begin
                if (d[7:3] != SYNC || d[2:0] > 3'd5) begin
                    ne = 1'b1;
                    frame.delete();
                end else if (d[2:0] < 3'd3) begin
                    nv       = 1'b1;
                    exp_type = d[2:0];
                    exp_data = 16'h0000;
                    frame.delete();
                end
            end else if (frame.size() == 2) begin
                exp_data[15:8] = d;
            end else begin
                val = {frame[1], frame[2]};
                if (val == 16'h0000) begin
                    ne = 1'b1;
                end else begin
                    nv       = 1'b1;
                    exp_type = frame[0][2:0];
                    exp_data = val;
                end
                frame.delete();
            end
        end else if (frame.size() > 0) begin
            gap++;
            if (gap == TMO) begin
                ne = 1'b1;
                frame.delete();
            end
        end
        exp_valid = nv;
        exp_err   = ne;
        bubble    = nv;
    endtask

    // One clock: drive at the falling edge, check outputs at the next falling edge.
    task automatic cycle(input logic v, input logic [7:0] d);
        byte_valid_i = v;
        byte_data_i  = d;
        check("byte_ready", 16'(byte_ready_o), 16'(!bubble));
        model_step(v, d);
        @(posedge clk_i);
        @(negedge clk_i);
        check("cmd_valid", 16'(cmd_valid_o), 16'(exp_valid));
        check("err", 16'(err_o), 16'(exp_err));
        check("cmd_type", 16'(cmd_type_o), 16'(exp_type));
        check("cmd_data", cmd_data_o, exp_data);
        check("valid_err_excl", 16'(cmd_valid_o & err_o), 16'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'($urandom));
    endtask

    task automatic send(input logic [7:0] b, input int max_gap);
        cycle(1'b1, b);
        if (max_gap > 0) idle($urandom_range(max_gap, 0));
    endtask

    initial begin
        int          kind;
        logic [7:0]  hi, lo;
        logic [2:0]  t;

        srst_i       = 1'b1;
        byte_valid_i = 1'b0;
        byte_data_i  = 8'h00;
        model_reset();
        #1;
        check("rst_valid", 16'(cmd_valid_o), 16'h0);
        check("rst_err", 16'(err_o), 16'h0);
        check("rst_type", 16'(cmd_type_o), 16'h0);
        check("rst_data", cmd_data_o, 16'h0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        srst_i = 1'b0;
        check("rst_ready", 16'(byte_ready_o), 16'h1);

        // Switch command without payload.
        cycle(1'b1, 8'hA8);
        check("on_valid", 16'(cmd_valid_o), 16'h1);
        check("on_type", 16'(cmd_type_o), 16'h0);
        check("on_data", cmd_data_o, 16'h0000);
        idle(2);

        // Red time 0x01F4, back-to-back; ready drops only in the emit cycle.
        cycle(1'b1, 8'hAC);
        cycle(1'b1, 8'h01);
        cycle(1'b1, 8'hF4);
        check("red_valid", 16'(cmd_valid_o), 16'h1);
        check("red_ready", 16'(byte_ready_o), 16'h0);
        check("red_type", 16'(cmd_type_o), 16'h4);
        check("red_data", cmd_data_o, 16'h01F4);
        idle(2);

        // Bad sync, then illegal type 6.
        cycle(1'b1, 8'h28);
        check("badsync_err", 16'(err_o), 16'h1);
        cycle(1'b1, 8'hAE);
        check("type6_err", 16'(err_o), 16'h1);
        idle(2);

        // Timeout after the high payload byte, then a fresh frame.
        cycle(1'b1, 8'hAB);
        cycle(1'b1, 8'h00);
        idle(TMO);
        check("tmo_err", 16'(err_o), 16'h1);
        cycle(1'b1, 8'hA9);
        check("after_tmo_type", 16'(cmd_type_o), 16'h1);
        idle(2);

        // Low byte arrives exactly at expiry: accepted, no error.
        cycle(1'b1, 8'hAB);
        cycle(1'b1, 8'h00);
        idle(TMO - 1);
        cycle(1'b1, 8'h05);
        check("expiry_valid", 16'(cmd_valid_o), 16'h1);
        check("expiry_data", cmd_data_o, 16'h0005);
        idle(2);

        // Zero duration is dropped.
        cycle(1'b1, 8'hAD);
        cycle(1'b1, 8'h00);
        cycle(1'b1, 8'h00);
        check("zero_err", 16'(err_o), 16'h1);
        idle(2);

        // Reset in the middle of a frame.
        cycle(1'b1, 8'hAD);
        cycle(1'b1, 8'h12);
        byte_valid_i = 1'b0;
        #2 srst_i = 1'b1;
        #1;
        check("midrst_data", cmd_data_o, 16'h0000);
        check("midrst_type", 16'(cmd_type_o), 16'h0);
        check("midrst_valid", 16'(cmd_valid_o), 16'h0);
        check("midrst_err", 16'(err_o), 16'h0);
        @(negedge clk_i);
        srst_i = 1'b0;
        model_reset();
        idle(TMO + 2);

        // Random frame traffic with random gaps, some crossing the timeout.
        for (int f = 0; f < 60; f++) begin
            kind = $urandom_range(4, 0);
            hi   = 8'($urandom);
            lo   = 8'($urandom);
            case (kind)
                0: begin
                    t = 3'($urandom_range(2, 0));
                    send({SYNC, t}, 2);
                end
                1: begin
                    t = 3'($urandom_range(5, 3));
                    if (hi == 8'h00 && lo == 8'h00) lo = 8'h01;
                    send({SYNC, t}, 3);
                    send(hi, 3);
                    send(lo, 2);
                end
                2: begin
                    send(8'($urandom), 2);
                end
                3: begin
                    send({SYNC, 3'd3}, 1);
                    send(8'h00, 1);
                    send(8'h00, 1);
                end
                default: begin
                    t = 3'($urandom_range(5, 3));
                    send({SYNC, t}, 1);
                    idle($urandom_range(TMO + 1, TMO - 1));
                    send(hi, 1);
                    send(lo, 1);
                end
            endcase
        end
        idle(TMO + 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
